coax_tx_feeder: RTL and testbench
=================================

// Module: coax_tx_feeder
// PURPOSE
//  Drains 10-bit words from the transmit-side coax_buffer FIFO into the coax transmitter as one frame.
//  Sits between the buffer read port and the transmitter word interface.
//  Handles the FIFO's one-cycle read latency and transmitter back-pressure.
//  Ends the frame on buffer empty or on a word limit, then waits for the line to go idle.
// PARAMETERS
//  MAX_WORDS    1024  frame word limit; 0 = unlimited (frame ends only on buffer empty)
//  COUNT_WIDTH  16    width of word_count
// PORTS
//  clk                 in   1   system clock, all logic on rising edge
//  reset_n             in   1   asynchronous, active-low reset
//  start               in   1   1-cycle pulse: begin a frame
//  abort               in   1   synchronous: abandon frame, return to IDLE
//  busy                out  1   high in any state other than IDLE
//  done                out  1   1-cycle pulse when a frame completes normally
//  word_count          out  CW  words strobed to transmitter in current/last frame
//  buffer_read_data    in   10  FIFO read data, valid the cycle after buffer_read_strobe
//  buffer_read_strobe  out  1   FIFO read enable, 1-cycle pulse
//  buffer_empty        in   1   FIFO empty flag
//  tx_data             out  10  word presented to transmitter, registered
//  tx_strobe           out  1   1-cycle pulse: transmitter accepts tx_data
//  tx_ready            in   1   transmitter can accept a word this cycle
//  tx_active           in   1   transmitter is driving the line
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE; busy, done, buffer_read_strobe, tx_strobe = 0;
//   tx_data = 0; word_count = 0. Takes effect immediately, with no clock edge required.
//  States: IDLE, FETCH, LOAD, SEND, DRAIN.
//  IDLE: start && !buffer_empty -> FETCH, word_count<=0.
//   start && buffer_empty is ignored: no read, busy stays 0, no done.
//   start outside IDLE is ignored.
//  FETCH: buffer_read_strobe=1 for exactly this cycle -> LOAD.
//  LOAD: tx_data<=buffer_read_data -> SEND.
//  SEND: tx_data held stable.
//   If tx_ready=0: stay in SEND; no strobe, no read.
//   If tx_ready=1: tx_strobe=1 for one cycle, word_count+1. Then:
//    buffer_empty=1, or (MAX_WORDS!=0 && new word_count==MAX_WORDS) -> DRAIN; else -> FETCH.
//  Throughput: minimum 3 clk per word (FETCH, LOAD, SEND).
//  DRAIN: 2-cycle fixed guard, then wait tx_active=0 -> IDLE with done=1 for that cycle.
//  abort (any non-IDLE state) -> IDLE on next edge.
//   No done pulse; tx_strobe=0 in the abort cycle; word_count holds its value.
//   A word read in FETCH/LOAD but not strobed is discarded.
//   Buffer contents are not flushed.
//  abort has priority over all other transitions; start and abort together in IDLE: remain IDLE.
//  Concurrent FIFO writes are allowed. A word written after buffer_empty is sampled in SEND
//   belongs to the next frame.
//  buffer_read_strobe is never asserted while buffer_empty=1. At most one read per word strobed.
//  word_count saturates at 2^COUNT_WIDTH-1 and does not wrap. It holds after done until the next start.
// TESTING
//  1. Preload 0x001,0x2AA,0x3FF; start, tx_ready=1
//      -> 3 tx_strobe carrying those values in order; done 1 pulse; word_count=3; busy=0 after.
//  2. Hold tx_ready=0 for 10 clk in SEND
//      -> tx_data stable, no tx_strobe, no buffer_read_strobe; resumes when tx_ready=1.
//  3. MAX_WORDS=4, preload 6 words; start
//      -> 4 strobes, done, 2 words remain; second start -> 2 strobes, word_count=2.
//  4. Empty buffer; start -> no buffer_read_strobe, busy=0, done=0.
//  5. abort in SEND after 2 words -> IDLE next clk; no done; word_count=2; no further strobes.
//  6. Hold tx_active=1 for 20 clk after last strobe -> done only after tx_active falls.
//  7. reset_n low mid-frame, between clock edges
//      -> all outputs 0 immediately; start after release begins a new frame.

Source files
------------

// File: rtl/coax_tx_feeder.sv
// Drains 10-bit words from the coax buffer FIFO into the transmitter, one frame per start.
// Covers the FIFO read latency, transmitter back-pressure, frame limit and line-idle wait.
module coax_tx_feeder #(
    parameter int MAX_WORDS   = 1024,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] word_count,
    input  logic [9:0]             buffer_read_data,
    output logic                   buffer_read_strobe,
    input  logic                   buffer_empty,
    output logic [9:0]             tx_data,
    output logic                   tx_strobe,
    input  logic                   tx_ready,
    input  logic                   tx_active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_DRAIN
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] LIMIT   = COUNT_WIDTH'(MAX_WORDS);

    state_t                   r_state;
    state_t                   w_next;
    logic [9:0]               r_tx_data;
    logic [COUNT_WIDTH-1:0]   r_count;
    logic [COUNT_WIDTH-1:0]   w_count_inc;
    logic [1:0]               r_guard;
    logic                     r_done;
    logic                     w_strobe;
    logic                     w_done_set;
    logic                     w_limit;

    assign w_count_inc = (r_count == CNT_MAX) ? r_count
                                              : r_count + COUNT_WIDTH'(1);
    assign w_limit     = (MAX_WORDS != 0) && (w_count_inc == LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort wins over every other transition, including a start in IDLE.
    always_comb begin
        w_next     = r_state;
        w_strobe   = 1'b0;
        w_done_set = 1'b0;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start && !buffer_empty) begin
                        w_next = S_FETCH;
                    end
                end
                S_FETCH: w_next = S_LOAD;
                S_LOAD:  w_next = S_SEND;
                S_SEND: begin
                    if (tx_ready) begin
                        w_strobe = 1'b1;
                        w_next   = (buffer_empty || w_limit) ? S_DRAIN
                                                             : S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (r_guard == 2'd2 && !tx_active) begin
                        w_next     = S_IDLE;
                        w_done_set = 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_data <= '0;
            r_count   <= '0;
            r_guard   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (r_state == S_IDLE && w_next == S_FETCH) begin
                r_count <= '0;
            end else if (w_strobe) begin
                r_count <= w_count_inc;
            end
            if (r_state == S_LOAD && !abort) begin
                r_tx_data <= buffer_read_data;
            end
            // Fixed guard before the line-idle check is honoured.
            if (r_state != S_DRAIN) begin
                r_guard <= '0;
            end else if (r_guard != 2'd2) begin
                r_guard <= r_guard + 2'd1;
            end
        end
    end

    assign busy               = (r_state != S_IDLE);
    assign done               = r_done;
    assign word_count         = r_count;
    assign buffer_read_strobe = (r_state == S_FETCH) && !abort;
    assign tx_data            = r_tx_data;
    assign tx_strobe          = w_strobe;

endmodule

// File: tb/tb_coax_tx_feeder.sv
// Scoreboard bench for coax_tx_feeder: FIFO model, expected-word queue, decoupled monitor.
// Directed frames first, then randomized frames with random back-pressure and line activity.
module tb_coax_tx_feeder;

    localparam int MAXW = 4;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [CW-1:0] word_count;
    logic [9:0]    buffer_read_data;
    logic          buffer_read_strobe;
    logic          buffer_empty;
    logic [9:0]    tx_data;
    logic          tx_strobe;
    logic          tx_ready;
    logic          tx_active;

    logic [9:0] fifo_q[$];
    logic [9:0] exp_q[$];
    int         exp_done_q[$];
    int         checks  = 0;
    int         errors  = 0;
    int         strobes = 0;
    int         reads   = 0;
    int         dones   = 0;

    always #5 clk = ~clk;

    coax_tx_feeder #(
        .MAX_WORDS   (MAXW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .abort              (abort),
        .busy               (busy),
        .done               (done),
        .word_count         (word_count),
        .buffer_read_data   (buffer_read_data),
        .buffer_read_strobe (buffer_read_strobe),
        .buffer_empty       (buffer_empty),
        .tx_data            (tx_data),
        .tx_strobe          (tx_strobe),
        .tx_ready           (tx_ready),
        .tx_active          (tx_active)
    );

    task automatic chk(input bit ok, input string name,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor and FIFO model: sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_strobe) begin
                strobes++;
                chk(tx_ready == 1'b1, "strobe_without_ready", tx_ready, 1);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_strobe", tx_data, 0);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    chk(tx_data == e, "tx_data", tx_data, e);
                end
            end
            if (buffer_read_strobe) begin
                reads++;
                chk(!buffer_empty, "read_while_empty", buffer_empty, 0);
                if (fifo_q.size() > 0) begin
                    buffer_read_data = fifo_q.pop_front();
                end
                buffer_empty = (fifo_q.size() == 0);
            end
            if (done) begin
                dones++;
                if (exp_done_q.size() == 0) begin
                    chk(1'b0, "unexpected_done", word_count, 0);
                end else begin
                    int n;
                    n = exp_done_q.pop_front();
                    chk(word_count == CW'(n), "done_word_count", word_count, n);
                end
                chk(exp_q.size() == 0, "frame_words_left", exp_q.size(), 0);
            end
        end
    end

    task automatic preload(input logic [9:0] w);
        fifo_q.push_back(w);
        buffer_empty = 1'b0;
    endtask

    // Reference: a frame carries the oldest min(fill, MAXW) words.
    task automatic do_start();
        int n;
        n = fifo_q.size();
        if (n > MAXW) n = MAXW;
        for (int i = 0; i < n; i++) exp_q.push_back(fifo_q[i]);
        if (n > 0) exp_done_q.push_back(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int max);
        int k;
        k = 0;
        while (strobes < target && k < max) begin
            @(posedge clk); #1;
            k++;
        end
        chk(strobes >= target, "strobe_timeout", strobes, target);
    endtask

    task automatic wait_done(input int target, input int max, input bit rnd);
        int k;
        k = 0;
        while (dones < target && k < max) begin
            @(posedge clk); #1;
            if (rnd) begin
                tx_ready  = 1'($urandom_range(0, 1));
                tx_active = ($urandom_range(0, 3) == 0);
            end
            k++;
        end
        chk(dones >= target, "done_timeout", dones, target);
    endtask

    initial begin
        int base;
        int n;
        reset_n          = 1'b0;
        start            = 1'b0;
        abort            = 1'b0;
        buffer_read_data = '0;
        buffer_empty     = 1'b1;
        tx_ready         = 1'b0;
        tx_active        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(busy == 0, "rst_busy", busy, 0);
        chk(done == 0, "rst_done", done, 0);
        chk(word_count == 0, "rst_count", word_count, 0);
        chk(tx_data == 0, "rst_tx_data", tx_data, 0);
        chk(tx_strobe == 0 && buffer_read_strobe == 0, "rst_strobes",
            {tx_strobe, buffer_read_strobe}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame of three words.
        preload(10'h001); preload(10'h2AA); preload(10'h3FF);
        tx_ready = 1'b1;
        do_start();
        wait_done(dones + 1, 100, 1'b0);
        chk(word_count == 3, "t1_count", word_count, 3);
        @(posedge clk); #1;
        chk(busy == 0, "t1_busy_after", busy, 0);

        // Back-pressure held in SEND.
        preload(10'h155); preload(10'h0F0); preload(10'h30C);
        base = strobes;
        do_start();
        wait_strobes(base + 1, 50);
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        base = strobes;
        n    = reads;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk(tx_data == 10'h0F0, "t2_tx_data_held", tx_data, 10'h0F0);
        end
        chk(strobes == base, "t2_no_strobe", strobes, base);
        chk(reads == n, "t2_no_read", reads, n);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_done(dones + 1, 100, 1'b0);

        // Word limit splits six words into 4 + 2.
        for (int i = 0; i < 6; i++) preload(10'(32 + i * 7));
        do_start();
        wait_done(dones + 1, 100, 1'b0);
        chk(fifo_q.size() == 2, "t3_words_remain", fifo_q.size(), 2);
        do_start();
        wait_done(dones + 1, 100, 1'b0);
        chk(word_count == 2, "t3_second_count", word_count, 2);

        // Start on an empty buffer is ignored.
        n = reads;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk(busy == 0 && done == 0, "t4_idle", {busy, done}, 0);
        end
        chk(reads == n, "t4_no_read", reads, n);

        // Abort in SEND after two words.
        for (int i = 0; i < 5; i++) preload(10'(900 + i));
        base = strobes;
        do_start();
        wait_strobes(base + 2, 50);
        tx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp_q.delete();
        exp_done_q.delete();
        tx_ready = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        chk(tx_strobe == 0, "t5_abort_strobe", tx_strobe, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk(busy == 0, "t5_idle_next", busy, 0);
        chk(word_count == 2, "t5_count", word_count, 2);
        base = strobes;
        n    = dones;
        repeat (10) @(posedge clk);
        #1;
        chk(strobes == base, "t5_no_more_strobes", strobes, base);
        chk(dones == n, "t5_no_done", dones, n);

        // Done waits for the line to go idle.
        preload(10'h011); preload(10'h022);
        tx_active = 1'b1;
        n    = (fifo_q.size() > MAXW) ? MAXW : fifo_q.size();
        base = strobes;
        do_start();
        wait_strobes(base + n, 100);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk(done == 0 && busy == 1, "t6_hold", {done, busy}, 1);
        end
        @(posedge clk); #1;
        tx_active = 1'b0;
        wait_done(dones + 1, 10, 1'b0);

        // Asynchronous reset mid-frame.
        preload(10'h1A1); preload(10'h1B2); preload(10'h1C3);
        base = strobes;
        do_start();
        wait_strobes(base + 1, 50);
        #3;
        reset_n = 1'b0;
        #1;
        chk(busy == 0 && done == 0, "t7_busy_done", {busy, done}, 0);
        chk(buffer_read_strobe == 0 && tx_strobe == 0, "t7_strobes",
            {buffer_read_strobe, tx_strobe}, 0);
        chk(tx_data == 0, "t7_tx_data", tx_data, 0);
        chk(word_count == 0, "t7_count", word_count, 0);
        exp_q.delete();
        exp_done_q.delete();
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_start();
        wait_done(dones + 1, 100, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) preload(10'($urandom));
            if (fifo_q.size() == 0) begin
                do_start();
                repeat (3) @(negedge clk);
                chk(busy == 0, "rnd_empty_idle", busy, 0);
                @(posedge clk); #1;
            end else begin
                do_start();
                wait_done(dones + 1, 600, 1'b1);
                tx_ready  = 1'b1;
                tx_active = 1'b0;
            end
        end
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
